// File: rtl/cmd_pkg.sv
// Shared constants and types for the panel-control command path.
package params;
    localparam int BYTES_PER_PIXEL = 3;
endpackage

package cmd_pkg;
    localparam logic [7:0] OPC_BLANKPANEL = 8'h5A;
    localparam logic [7:0] OPC_FILLPANEL  = 8'h46;
    localparam logic [7:0] OPC_NOP        = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARGS,
        ST_RUN,
        ST_RELEASE
    } dispatch_fsm_t;

    typedef enum logic {
        TGT_BLANK,
        TGT_FILL
    } cmd_target_t;
endpackage

// File: rtl/cmd_watchdog.sv
// Saturating up-counter that flags a command holding enable too long.
module cmd_watchdog #(
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= CNT_LAST);
endmodule

// File: rtl/control_cmd_dispatch.sv
// Decodes UART opcode/argument bytes and enables one panel command block at a time.
module control_cmd_dispatch
    import cmd_pkg::*;
#(
    parameter int BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
    parameter int TIMEOUT_CYCLES  = 2**20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   data_rx,
    input  logic                         data_rx_ready,
    output logic                         ready_for_data,
    output logic                         blankpanel_enable,
    input  logic                         blankpanel_done,
    output logic                         fillpanel_enable,
    output logic [BYTES_PER_PIXEL*8-1:0] fillpanel_color,
    input  logic                         fillpanel_done,
    output logic                         busy,
    output logic                         err_opcode,
    output logic                         err_overrun,
    output logic                         err_timeout
);
    localparam int COLOR_W = BYTES_PER_PIXEL * 8;
    localparam int ARG_W   = $clog2(BYTES_PER_PIXEL + 1);
    localparam logic [ARG_W-1:0] ARG_LAST = ARG_W'(BYTES_PER_PIXEL - 1);

    dispatch_fsm_t      state, state_n;
    cmd_target_t        target, target_n;
    logic [COLOR_W-1:0] color_n;
    logic [ARG_W-1:0]   arg_cnt, arg_cnt_n;
    logic               err_opcode_n, err_overrun_n, err_timeout_n;
    logic               sel_done, wd_expired;

    cmd_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_RUN),
        .enable  (state == ST_RUN),
        .expired (wd_expired)
    );

    assign sel_done = (target == TGT_BLANK) ? blankpanel_done : fillpanel_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ST_IDLE;
            target          <= TGT_BLANK;
            fillpanel_color <= '0;
            arg_cnt         <= '0;
            err_opcode      <= 1'b0;
            err_overrun     <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            state           <= state_n;
            target          <= target_n;
            fillpanel_color <= color_n;
            arg_cnt         <= arg_cnt_n;
            err_opcode      <= err_opcode_n;
            err_overrun     <= err_overrun_n;
            err_timeout     <= err_timeout_n;
        end
    end

    always_comb begin
        state_n       = state;
        target_n      = target;
        color_n       = fillpanel_color;
        arg_cnt_n     = arg_cnt;
        err_opcode_n  = err_opcode;
        err_overrun_n = err_overrun;
        err_timeout_n = err_timeout;
        case (state)
            ST_IDLE: begin
                if (data_rx_ready) begin
                    case (data_rx)
                        OPC_BLANKPANEL: begin
                            state_n       = ST_RUN;
                            target_n      = TGT_BLANK;
                            err_opcode_n  = 1'b0;
                            err_overrun_n = 1'b0;
                            err_timeout_n = 1'b0;
                        end
                        OPC_FILLPANEL: begin
                            state_n       = ST_ARGS;
                            arg_cnt_n     = '0;
                            color_n       = '0;
                            err_opcode_n  = 1'b0;
                            err_overrun_n = 1'b0;
                            err_timeout_n = 1'b0;
                        end
                        OPC_NOP: ;
                        default: err_opcode_n = 1'b1;
                    endcase
                end
            end
            ST_ARGS: begin
                if (data_rx_ready) begin
                    // First byte received ends up in the MSB after all shifts.
                    color_n   = (fillpanel_color << 8) | COLOR_W'(data_rx);
                    arg_cnt_n = arg_cnt + 1'b1;
                    if (arg_cnt == ARG_LAST) begin
                        state_n  = ST_RUN;
                        target_n = TGT_FILL;
                    end
                end
            end
            ST_RUN: begin
                if (data_rx_ready) err_overrun_n = 1'b1;
                // A done on the same cycle as expiry counts as normal completion.
                if (sel_done) begin
                    state_n = ST_RELEASE;
                end else if (wd_expired) begin
                    state_n       = ST_RELEASE;
                    err_timeout_n = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (data_rx_ready) err_overrun_n = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign ready_for_data    = (state == ST_IDLE) || (state == ST_ARGS);
    assign busy              = (state != ST_IDLE);
    assign blankpanel_enable = (state == ST_RUN) && (target == TGT_BLANK);
    assign fillpanel_enable  = (state == ST_RUN) && (target == TGT_FILL);
endmodule

// File: doc/control_cmd_dispatch.md
# control_cmd_dispatch

- Command front end for the panel-control path.
- Takes opcode and argument bytes from the UART receive stage and decodes them.
- Enables exactly one command block: `control_cmd_blankpanel` or the solid-colour fill command. Holds it enabled until its `done` pulse, then returns to idle.
- Sits directly upstream of the command blocks. Flags unknown opcodes, byte overruns and stalled commands.

## Interface
Parameters:
- `BYTES_PER_PIXEL`, default `params::BYTES_PER_PIXEL`: colour bytes collected for a fill.
- `TIMEOUT_CYCLES`, default `2**20`: maximum cycles a command may hold enable before it is aborted.

Ports:
- `clk` in 1: single clock; every register is clocked on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk`, low forces every output to its reset value.
- `data_rx` in 8: received byte.
- `data_rx_ready` in 1: one-cycle strobe, `data_rx` valid.
- `ready_for_data` out 1: high when a byte strobe will be consumed.
- `blankpanel_enable` out 1: enable to blank-panel command.
- `blankpanel_done` in 1: one-cycle done pulse from blank-panel command.
- `fillpanel_enable` out 1: enable to fill command.
- `fillpanel_color` out `BYTES_PER_PIXEL*8`: collected fill colour, first byte is MSB.
- `fillpanel_done` in 1: one-cycle done pulse from fill command.
- `busy` out 1: a command is accepted and not yet complete.
- `err_opcode` out 1: sticky, unknown opcode seen.
- `err_overrun` out 1: sticky, byte arrived while not ready.
- `err_timeout` out 1: sticky, command aborted by watchdog.

## Operation
- Reset values: all enables 0, `fillpanel_color` 0, `busy` 0, all `err_*` 0, `ready_for_data` 1, state IDLE, counters 0.
- States: IDLE, ARGS, RUN, RELEASE.
- IDLE, on byte strobe:
  - `OPC_BLANKPANEL` (8'h5A): latch the blank-panel target and go to RUN.
  - `OPC_FILLPANEL` (8'h46): clear the argument counter and go to ARGS.
  - `OPC_NOP` (8'h00): ignored.
  - Any other value: set `err_opcode` and stay in IDLE.
- ARGS:
  - Each strobe shifts `data_rx` into `fillpanel_color` from the LSB side, so the first byte ends up in the MSB.
  - After `BYTES_PER_PIXEL` bytes, latch the fill target and go to RUN.
- RUN:
  - The selected enable is high and the other stays low.
  - The watchdog counter increments every cycle.
  - On the selected target's `done` pulse: go to RELEASE.
  - On the watchdog reaching `TIMEOUT_CYCLES - 1`: set `err_timeout` and go to RELEASE.
  - A `done` from the non-selected target is ignored.
- RELEASE: enables low, watchdog cleared, go to IDLE. This gives the command block one cycle to finish its own reset.
- Any accepted opcode byte other than NOP clears all `err_*` flags in the same cycle.
- Byte strobe in RUN or RELEASE: byte dropped, `err_overrun` set.
- Width rule: watchdog counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates. The argument counter is `$clog2(BYTES_PER_PIXEL+1)` bits.

## Timing
- `ready_for_data` is high in IDLE and ARGS; combinational from state only.
- Latency for blank-panel: opcode strobe at cycle N gives `blankpanel_enable` and `busy` high at N+1.
- Latency for fill: last colour strobe at cycle M gives `fillpanel_enable` high at M+1. `busy` rises on the `OPC_FILLPANEL` strobe cycle + 1.
- `fillpanel_color` is stable from enable rise until the next `OPC_FILLPANEL` is accepted.
- `done` sampled high at cycle D: enable low at D+1, and D+1 is the RELEASE cycle. Back in IDLE at D+2 with `busy` low and `ready_for_data` high.
- `done` and watchdog expiry on the same cycle: treated as normal completion, `err_timeout` not set.
- Reset asserted mid-command: enables low and `busy` low on the next edge. A partial ARGS colour is discarded (reset to 0).

## Structure
- Shared package `cmd_pkg`:
  - Opcode constants `OPC_BLANKPANEL`, `OPC_FILLPANEL`, `OPC_NOP`.
  - Dispatch state enum `dispatch_fsm_t`.
  - Target enum `cmd_target_t` (TGT_BLANK, TGT_FILL).
- One sub-module is natural: `cmd_watchdog`, a counter with clear, enable and a saturating `expired` output, parameterised by `TIMEOUT_CYCLES`.
- Everything else stays in the single FSM.

## Test plan
- Reset low for 2 cycles, then high → all outputs at reset values, `ready_for_data`=1.
- Strobe 8'h5A; bench `blankpanel_done` pulses 10 cycles after enable rises → enable high 10 cycles, low on the next cycle, `busy` low 2 cycles after `done`, `fillpanel_enable` never high.
- `BYTES_PER_PIXEL`=2: strobe 8'h46, 8'hF8, 8'h1F → `fillpanel_color`=16'hF81F and `fillpanel_enable` high one cycle after the 8'h1F strobe; `done` pulse → clean return to IDLE.
- Strobe 8'h33 → `err_opcode`=1, no enable asserted; then strobe 8'h5A → `err_opcode` cleared.
- `TIMEOUT_CYCLES`=16, strobe 8'h5A, `done` never asserted → enable drops after 16 cycles high, `err_timeout`=1. Also a byte strobed during RUN → `err_overrun`=1.
- Reset driven low during ARGS after one colour byte → `fillpanel_color`=0 and state IDLE. A following 8'h5A runs normally.
